arb_req_agent: RTL

Requester-side agent for the 4-port combinational arbiter. It sits between transaction sources and the arbiter's req/gnt interface: it queues per-port transaction counts, drives `req_o` toward the arbiter, and consumes `gnt_i` one transaction per accepted grant. It also checks every grant for protocol legality and flags ports that wait too long.

---
 rtl/arb_req_agent.sv | 117 +++++++++++
 1 files changed

// File: rtl/arb_req_agent.sv
// arb_req_agent: requester-side agent for a 4-port combinational arbiter.
// Queues per-port transaction counts, raises req_o while work is pending,
// consumes one transaction per legal accepted grant, and raises sticky flags
// for illegal grants, dropped pushes and starved ports.
module arb_req_agent #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         push_i,
  input  logic [NUM_PORTS-1:0]         gnt_i,
  input  logic                         err_clr_i,
  output logic [NUM_PORTS-1:0]         req_o,
  output logic [NUM_PORTS*CNT_W-1:0]   pend_cnt_o,
  output logic [NUM_PORTS-1:0]         full_o,
  output logic [NUM_PORTS-1:0]         done_o,
  output logic [NUM_PORTS-1:0]         ovf_o,
  output logic [NUM_PORTS-1:0]         starve_o,
  output logic                         err_o
);

  localparam int unsigned WCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [WCNT_W-1:0] WCNT_LIM  = WCNT_W'(STARVE_LIMIT);

  logic [NUM_PORTS-1:0][CNT_W-1:0]  r_cnt;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  w_cnt_nxt;
  logic [NUM_PORTS-1:0][WCNT_W-1:0] r_wcnt;
  logic [NUM_PORTS-1:0][WCNT_W-1:0] w_wcnt_nxt;
  logic [NUM_PORTS-1:0]             r_done;
  logic [NUM_PORTS-1:0]             r_ovf;
  logic [NUM_PORTS-1:0]             r_starve;
  logic                             r_err;

  logic [NUM_PORTS-1:0]             w_req;
  logic [NUM_PORTS-1:0]             w_full;
  logic [NUM_PORTS-1:0]             w_acc;
  logic [NUM_PORTS-1:0]             w_ovf_set;
  logic [NUM_PORTS-1:0]             w_starve_set;
  logic                             w_multi;
  logic                             w_illegal;

  // Request/full decode from registered counts only (no input-to-req path).
  always_comb begin
    w_req  = '0;
    w_full = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      w_req[p]  = (r_cnt[p] != '0);
      w_full[p] = (r_cnt[p] == CNT_MAX);
    end
  end

  // Grant legality: more than one bit, or any grant to a non-requesting port.
  always_comb begin
    w_multi   = ((gnt_i & (gnt_i - NUM_PORTS'(1))) != '0);
    w_illegal = w_multi | ((gnt_i & ~w_req) != '0);
    w_acc     = w_illegal ? '0 : (gnt_i & w_req);
  end

  // Next-state for pending and wait counters plus flag set conditions.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_wcnt_nxt   = r_wcnt;
    w_ovf_set    = '0;
    w_starve_set = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      // Push and accept together cancel out, even when full.
      if (w_acc[p] && !push_i[p]) begin
        w_cnt_nxt[p] = r_cnt[p] - CNT_W'(1);
      end else if (push_i[p] && !w_acc[p]) begin
        if (w_full[p]) begin
          w_ovf_set[p] = 1'b1;
        end else begin
          w_cnt_nxt[p] = r_cnt[p] + CNT_W'(1);
        end
      end

      if (!w_req[p] || w_acc[p]) begin
        w_wcnt_nxt[p] = '0;
      end else if (r_wcnt[p] != WCNT_LIM) begin
        w_wcnt_nxt[p] = r_wcnt[p] + WCNT_W'(1);
      end
      // Flag only on the edge where the wait counter first reaches the limit.
      w_starve_set[p] = (w_wcnt_nxt[p] == WCNT_LIM) && (r_wcnt[p] != WCNT_LIM);
    end
  end

  // State and sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_wcnt   <= '0;
      r_done   <= '0;
      r_ovf    <= '0;
      r_starve <= '0;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_done   <= w_acc;
      r_ovf    <= w_ovf_set | (err_clr_i ? '0 : r_ovf);
      r_starve <= w_starve_set | (err_clr_i ? '0 : r_starve);
      r_err    <= w_illegal | (r_err & ~err_clr_i);
    end
  end

  assign req_o      = w_req;
  assign full_o     = w_full;
  assign pend_cnt_o = r_cnt;
  assign done_o     = r_done;
  assign ovf_o      = r_ovf;
  assign starve_o   = r_starve;
  assign err_o      = r_err;

endmodule
